// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding fixed-length messages from two requesters
// into a single UART transmitter, one byte per write/busy handshake.
module uart_tx_arbiter #(
    parameter int MSG_LEN  = 14,
    parameter int BUSY_TMO = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic [3:0] rd_idx,
    input  logic [7:0] rd_data0,
    input  logic [7:0] rd_data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_busy,
    output logic       done0,
    output logic       done1
);

    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);
    localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    pend;
    logic          last;
    logic [TW-1:0] tmo_cnt;
    logic          pick1;
    logic [1:0]    clr;

    // Both pending: take the one not served last; otherwise the only one.
    always_comb begin
        pick1 = 1'b0;
        if (pend == 2'b11)
            pick1 = ~last;
        else
            pick1 = pend[1];
    end

    always_comb begin
        clr = 2'b00;
        if (state == ARB && pend != 2'b00)
            clr = pick1 ? 2'b10 : 2'b01;
    end

    // A new pulse wins over the grant-time clear so a repeat is never lost.
    always_ff @(posedge clk) begin
        if (rst)
            pend <= 2'b00;
        else
            pend <= (pend & ~clr) | {req1, req0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            rd_idx  <= 4'd0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            tx_wr   <= 1'b0;
            tx_data <= 8'd0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            tx_wr <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pend != 2'b00)
                        state <= ARB;
                end
                ARB: begin
                    if (pend != 2'b00) begin
                        gnt0   <= ~pick1;
                        gnt1   <= pick1;
                        last   <= pick1;
                        rd_idx <= 4'd0;
                        state  <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    tx_wr   <= 1'b1;
                    tx_data <= gnt1 ? rd_data1 : rd_data0;
                    tmo_cnt <= '0;
                    state   <= WAIT_HI;
                end
                WAIT_HI: begin
                    // A transmitter that never raises busy must not stall us.
                    if (tx_busy || tmo_cnt == TMO_LAST)
                        state <= WAIT_LO;
                    else
                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (rd_idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            rd_idx <= rd_idx + 4'd1;
                            state  <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    done0 <= gnt0;
                    done1 <= gnt1;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    state <= (pend != 2'b00) ? ARB : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
